// File: rtl/kamikaze_ifq_pkg.sv
// Shared types and constants for the kamikaze instruction fetch queue.
// Holds the NOP encoding, the datapath width and the 65-bit queue entry layout.
package kamikaze_ifq_pkg;

    localparam int          KAMIKAZE_XLEN = 32;
    localparam logic [31:0] KAMIKAZE_NOP  = 32'h0000_0013;

    // One queue entry: instruction, its PC and the compressed-origin flag.
    typedef struct packed {
        logic [KAMIKAZE_XLEN-1:0] instr;
        logic [KAMIKAZE_XLEN-1:0] pc;
        logic                     compressed;
    } ifq_entry_t;

    localparam int KAMIKAZE_ENTRY_W = $bits(ifq_entry_t);

    // Fall-through PC: 16-bit encodings advance by 2, 32-bit encodings by 4.
    function automatic logic [KAMIKAZE_XLEN-1:0] next_pc(input ifq_entry_t e);
        return e.pc + (e.compressed ? 32'd2 : 32'd4);
    endfunction

endpackage

// File: rtl/kamikaze_ifq_ram.sv
// Entry storage for the fetch queue: DEPTH entries, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module kamikaze_ifq_ram
    import kamikaze_ifq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  ifq_entry_t        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output ifq_entry_t        rdata_o
);

    ifq_entry_t mem [DEPTH];

    // Write the addressed entry on a push.
    // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/kamikaze_ifq.sv
// Instruction fetch queue between fetch and decode.
// Buffers decompressed instructions with PC and compressed flag, back-pressures
// fetch when full and drops everything on flush_i.
// Optional feature: define KAMIKAZE_IFQ_BYPASS_EN to forward the input straight
// to the outputs while the queue is empty (zero-cycle latency).
module kamikaze_ifq
    import kamikaze_ifq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc_i,
    input  logic              is_compressed_instr_i,
    input  logic              instr_valid_i,
    output logic              ifq_ready_o,
    input  logic              flush_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       next_pc_o,
    output logic              is_compressed_instr_o,
    output logic              instr_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W:0]   ifq_count_o
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    ifq_entry_t in_entry;
    ifq_entry_t rd_entry;
    ifq_entry_t head_entry;
    logic       queue_empty;
    logic       bypass_active;
    logic       head_valid;
    logic       push;
    logic       pop;
    logic       mem_push;
    logic       mem_pop;

    assign in_entry    = '{instr: instr_i, pc: pc_i, compressed: is_compressed_instr_i};
    assign queue_empty = (count_q == '0);

    // Ready depends on registered occupancy only, so no id_ready_i -> ifq_ready_o path.
    assign ifq_ready_o = (count_q != COUNT_FULL);

`ifdef KAMIKAZE_IFQ_BYPASS_EN
    assign bypass_active = queue_empty & instr_valid_i & ~flush_i;
`else
    assign bypass_active = 1'b0;
`endif

    assign head_valid = ~queue_empty | bypass_active;
    assign head_entry = bypass_active ? in_entry : rd_entry;

    assign push = instr_valid_i & ifq_ready_o & ~flush_i;
    assign pop  = head_valid & id_ready_i & ~flush_i;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign mem_push = push & ~(bypass_active & id_ready_i);
    assign mem_pop  = pop & ~queue_empty;

    kamikaze_ifq_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (mem_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Next pointer and occupancy; flush clears everything and suppresses push/pop.
    // NOTE: every signal gets a default at the top of the block so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (mem_push) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (mem_pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({mem_push, mem_pop})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head outputs, forced to idle values when no valid head exists.
    always_comb begin
        instr_valid_o         = head_valid;
        instr_o               = KAMIKAZE_NOP;
        pc_o                  = '0;
        next_pc_o             = '0;
        is_compressed_instr_o = 1'b0;
        if (head_valid) begin
            instr_o               = head_entry.instr;
            pc_o                  = head_entry.pc;
            next_pc_o             = next_pc(head_entry);
            is_compressed_instr_o = head_entry.compressed;
        end
    end

    assign ifq_count_o = count_q;

endmodule
